sd_frame_loader: RTL
====================

# sd_frame_loader

Sequencer and arbiter for the single-port frame RAM between the SD-card read controller and the VGA driver. After SD initialisation it reads `NUM_SEC` consecutive sectors from `START_SEC` and writes each 16-bit RGB565 word into RAM. It then hands the RAM to the VGA pixel fetch path, converting each word to 12-bit RGB444 `color_data`. A reload pulse repeats the load.

## Interface
- `START_SEC`, 32'd16640: first SD sector of the image.
- `NUM_SEC`, 16'd600: sectors per frame (256 words each).
- `ADDR_W`, 18: RAM word-address width.
- `TIMEOUT`, 16'd50000: cycles allowed for `rd_busy` to rise after `rd_start_en`.

Ports:
- `sys_clk` in 1: single clock (25 MHz). All logic is on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `sd_init_done` in 1: SD controller initialisation complete (level).
- `rd_busy` in 1: SD sector read in progress.
- `rd_val_en` in 1: `rd_val_data` valid this cycle.
- `rd_val_data` in 16: sector data word.
- `rd_start_en` out 1: one-cycle read-request pulse.
- `rd_sec_addr` out 32: sector address, held stable from the pulse until the read completes.
- `ena` out 1: RAM enable.
- `wena` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM word address.
- `data_in` out 16: RAM write data.
- `data_out` in 16: RAM read data (synchronous, 1-cycle latency).
- `reload` in 1: pulse; restart the load when in DONE.
- `pix_req` in 1: VGA active-video fetch strobe.
- `pix_addr` in ADDR_W: pixel word address.
- `color_data` out 12: RGB444 pixel to the VGA driver.
- `load_busy` out 1: load in progress.
- `frame_done` out 1: frame fully loaded.
- `load_err` out 1: timeout occurred (sticky until reload or reset).

## Operation
- States and transitions:
  - IDLE → START when `sd_init_done`=1.
  - START: pulse `rd_start_en` for 1 cycle with `rd_sec_addr = START_SEC + sec_cnt`; → WAIT_BUSY.
  - WAIT_BUSY: → XFER on `rd_busy`=1. If the timeout counter reaches `TIMEOUT`, set `load_err` and → ERR.
  - XFER: each `rd_val_en` cycle drives `ena`=`wena`=1, `ram_addr=wr_ptr`, `data_in=rd_val_data`, then increments `wr_ptr` and `word_cnt`. Words beyond 256 in one sector are dropped (no write, no increment). On `rd_busy` falling → NEXT.
  - NEXT: if `sec_cnt==NUM_SEC-1` → DONE, else `sec_cnt++`, → START.
  - DONE: `frame_done`=1. `reload` clears `sec_cnt`, `wr_ptr`, `frame_done` and → START.
  - ERR: stays until `reload`, which clears `load_err` and → START. `reload` in any other state is ignored.
- A short sector (<256 words) does not stall the load. `wr_ptr` is rounded up to the next multiple of 256 at NEXT so sector alignment is preserved.
- Arbitration:
  - Outside DONE, the RAM belongs to the loader; `pix_req` is ignored and `color_data`=0 (blanked).
  - In DONE, `pix_req` drives `ena`=1, `wena`=0, `ram_addr=pix_addr`.
  - `wena` is never 1 in DONE.
- Colour conversion: `color_data = {d[15:12], d[10:7], d[4:1]}`, registered.
- `wr_ptr` wraps modulo 2^ADDR_W. Keeping `NUM_SEC*256 ≤ 2^ADDR_W` is the integrator's responsibility.
- `sd_init_done` falling in any state other than IDLE forces IDLE. Counters clear, and `frame_done` and `load_err` clear.

## Timing
- Reset values: `rd_start_en`=0, `rd_sec_addr`=`START_SEC`, `ena`=`wena`=0, `ram_addr`=0, `data_in`=0, `color_data`=0, `load_busy`=0, `frame_done`=0, `load_err`=0. State is IDLE.
- `rd_start_en` asserts 1 cycle after entering START and is exactly 1 cycle wide.
- RAM write strobe, address and data are registered outputs, 1 cycle after the `rd_val_en` sample.
- Pixel latency: `pix_req`/`pix_addr` at cycle N → RAM read at N+1 → `color_data` valid at N+2.
- `load_busy` is high in START, WAIT_BUSY, XFER and NEXT.
- `rd_val_en` and `reload` arriving in the same cycle: the data word is written and `reload` is ignored (not in DONE).

## Structure
- A shared package `sd_frame_pkg` holds:
  - the state enum (IDLE, START, WAIT_BUSY, XFER, NEXT, DONE, ERR);
  - `SEC_WORDS`=256;
  - the RGB565→RGB444 conversion function.
- One natural sub-module: `rgb565_to_444`, a registered pixel converter.

## Test plan
- SD model with `NUM_SEC`=2, `START_SEC`=100: `sd_init_done` rises → `rd_sec_addr` 100 then 101. 512 RAM writes at addresses 0–511 with data matching the model. `frame_done`=1, `load_busy`=0.
- DONE with `pix_req`=1, `pix_addr`=5, RAM[5]=16'hF81F → `color_data`=12'hF0F two cycles later, with `wena`=0 throughout.
- Model never raises `rd_busy`, `TIMEOUT`=100 → `load_err`=1 after 100 cycles in WAIT_BUSY. `reload` clears it and reissues sector `START_SEC`.
- Sector returns 300 words → only 256 written. Next sector begins at address 256.
- `reload` in DONE → `frame_done` drops within 1 cycle and `rd_start_en` pulses with `rd_sec_addr`=`START_SEC`. `reload` during XFER → no effect.
- `sys_rst_n` low mid-XFER → all outputs return to reset values immediately (asynchronously). After release the load restarts from sector 0.

Source files
------------

// File: rtl/sd_frame_pkg.sv
// Shared types and helpers for the SD-card frame loader.
// Holds the sequencer state encoding, sector geometry and the pixel colour reduction.
package sd_frame_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        XFER      = 3'd3,
        NEXT      = 3'd4,
        DONE      = 3'd5,
        ERR       = 3'd6
    } state_t;

    localparam int SEC_WORDS  = 256;
    localparam int WORD_CNT_W = 9;

    // RGB565 to RGB444: keep the top four bits of each channel.
    function automatic logic [11:0] rgb565_to_rgb444(input logic [15:0] d);
        return {d[15:12], d[10:7], d[4:1]};
    endfunction

endpackage

// File: rtl/rgb565_to_444.sv
// Registered pixel converter between the frame RAM read port and the VGA driver.
// Output is forced to black whenever the frame is not being displayed.
module rgb565_to_444
    import sd_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        show,
    input  logic [15:0] pix_in,
    output logic [11:0] color_out
);

    logic [11:0] color_r;

    // Convert the RAM read word, or blank when the frame is not on display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_r <= 12'h000;
        end else if (srst || !show) begin
            color_r <= 12'h000;
        end else begin
            color_r <= rgb565_to_rgb444(pix_in);
        end
    end

    assign color_out = color_r;

endmodule

// File: rtl/sd_frame_loader.sv
// Loads a frame from consecutive SD sectors into the single-port frame RAM,
// then hands the RAM over to the VGA pixel fetch path.
module sd_frame_loader
    import sd_frame_pkg::*;
#(
    parameter logic [31:0] START_SEC = 32'd16640,
    parameter logic [15:0] NUM_SEC   = 16'd600,
    parameter int          ADDR_W    = 18,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              sd_init_done,
    input  logic              rd_busy,
    input  logic              rd_val_en,
    input  logic [15:0]       rd_val_data,
    output logic              rd_start_en,
    output logic [31:0]       rd_sec_addr,
    output logic              ena,
    output logic              wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       data_in,
    input  logic [15:0]       data_out,
    input  logic              reload,
    input  logic              pix_req,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic [11:0]       color_data,
    output logic              load_busy,
    output logic              frame_done,
    output logic              load_err
);

    localparam logic [ADDR_W-1:0]     SEC_MASK = ADDR_W'(SEC_WORDS - 1);
    localparam logic [WORD_CNT_W-1:0] SEC_LEN  = WORD_CNT_W'(SEC_WORDS);

    state_t                  state_r;
    logic [15:0]             sec_cnt_r;
    logic [ADDR_W-1:0]       wr_ptr_r;
    logic [WORD_CNT_W-1:0]   word_cnt_r;
    logic [15:0]             tmo_cnt_r;
    logic                    rd_start_en_r;
    logic [31:0]             rd_sec_addr_r;
    logic                    ena_r;
    logic                    wena_r;
    logic [ADDR_W-1:0]       ram_addr_r;
    logic [15:0]             data_in_r;
    logic                    load_busy_r;
    logic                    frame_done_r;
    logic                    load_err_r;
    logic                    srst_s;

    // Losing SD initialisation outside IDLE abandons the load and starts over.
    assign srst_s = (state_r != IDLE) && !sd_init_done;

    // Load sequencer and RAM arbiter; every output is a register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r       <= IDLE;
            sec_cnt_r     <= 16'd0;
            wr_ptr_r      <= '0;
            word_cnt_r    <= '0;
            tmo_cnt_r     <= 16'd0;
            rd_start_en_r <= 1'b0;
            rd_sec_addr_r <= START_SEC;
            ena_r         <= 1'b0;
            wena_r        <= 1'b0;
            ram_addr_r    <= '0;
            data_in_r     <= 16'h0000;
            load_busy_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            load_err_r    <= 1'b0;
        end else if (srst_s) begin
            state_r       <= IDLE;
            sec_cnt_r     <= 16'd0;
            wr_ptr_r      <= '0;
            word_cnt_r    <= '0;
            tmo_cnt_r     <= 16'd0;
            rd_start_en_r <= 1'b0;
            ena_r         <= 1'b0;
            wena_r        <= 1'b0;
            load_busy_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            load_err_r    <= 1'b0;
        end else begin
            rd_start_en_r <= 1'b0;
            ena_r         <= 1'b0;
            wena_r        <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sd_init_done) begin
                        load_busy_r <= 1'b1;
                        state_r     <= START;
                    end
                end
                START: begin
                    rd_start_en_r <= 1'b1;
                    rd_sec_addr_r <= START_SEC + {16'd0, sec_cnt_r};
                    tmo_cnt_r     <= 16'd0;
                    state_r       <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (rd_busy) begin
                        word_cnt_r <= '0;
                        state_r    <= XFER;
                    end else if (tmo_cnt_r == TIMEOUT - 16'd1) begin
                        load_err_r  <= 1'b1;
                        load_busy_r <= 1'b0;
                        state_r     <= ERR;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
                end
                XFER: begin
                    // Over-long sectors are truncated so they cannot spill into the next slot.
                    if (rd_val_en && (word_cnt_r < SEC_LEN)) begin
                        ena_r      <= 1'b1;
                        wena_r     <= 1'b1;
                        ram_addr_r <= wr_ptr_r;
                        data_in_r  <= rd_val_data;
                        wr_ptr_r   <= wr_ptr_r + ADDR_W'(1);
                        word_cnt_r <= word_cnt_r + WORD_CNT_W'(1);
                    end
                    if (!rd_busy) begin
                        state_r <= NEXT;
                    end
                end
                NEXT: begin
                    // Round up so a short sector still leaves the next one sector-aligned.
                    wr_ptr_r   <= (wr_ptr_r + SEC_MASK) & ~SEC_MASK;
                    word_cnt_r <= '0;
                    if (sec_cnt_r == NUM_SEC - 16'd1) begin
                        frame_done_r <= 1'b1;
                        load_busy_r  <= 1'b0;
                        state_r      <= DONE;
                    end else begin
                        sec_cnt_r <= sec_cnt_r + 16'd1;
                        state_r   <= START;
                    end
                end
                DONE: begin
                    if (reload) begin
                        sec_cnt_r    <= 16'd0;
                        wr_ptr_r     <= '0;
                        frame_done_r <= 1'b0;
                        load_busy_r  <= 1'b1;
                        state_r      <= START;
                    end else if (pix_req) begin
                        ena_r      <= 1'b1;
                        ram_addr_r <= pix_addr;
                    end
                end
                ERR: begin
                    if (reload) begin
                        sec_cnt_r   <= 16'd0;
                        wr_ptr_r    <= '0;
                        load_err_r  <= 1'b0;
                        load_busy_r <= 1'b1;
                        state_r     <= START;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    rgb565_to_444 u_conv (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .srst      (srst_s),
        .show      (frame_done_r),
        .pix_in    (data_out),
        .color_out (color_data)
    );

    assign rd_start_en = rd_start_en_r;
    assign rd_sec_addr = rd_sec_addr_r;
    assign ena         = ena_r;
    assign wena        = wena_r;
    assign ram_addr    = ram_addr_r;
    assign data_in     = data_in_r;
    assign load_busy   = load_busy_r;
    assign frame_done  = frame_done_r;
    assign load_err    = load_err_r;

endmodule
